// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and helpers for the PE-array control slice: drain FSM states,
// default counter widths and a 1-bit-to-per-PE broadcast helper.
package pe_array_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  localparam int unsigned DEF_MAX_ENTRIES     = 64;
  localparam int unsigned DEF_ENTRY_CNT_WIDTH = $clog2(DEF_MAX_ENTRIES + 1);
  localparam int unsigned MAX_BCAST_WIDTH     = 4096;

  function automatic int unsigned entry_cnt_w(input int unsigned max_entries);
    return $clog2(max_entries + 1);
  endfunction

  // A single-column array still needs a 1-bit column field.
  function automatic int unsigned col_cnt_w(input int unsigned num_col);
    return (num_col > 1) ? $clog2(num_col) : 1;
  endfunction

  // Callers size-cast the result down to their own PE count.
  function automatic logic [MAX_BCAST_WIDTH-1:0] broadcast(input logic ctrl);
    return {MAX_BCAST_WIDTH{ctrl}};
  endfunction

endpackage

// File: rtl/pe_array_drain_ctrl.sv
// Drains ACCFIFO results rightward along the systolic chain, one word per row per beat.
// Optional macro PE_DRAIN_ZERO_REFILL_EN: refill every drained entry with zero during LOAD.
module pe_array_drain_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int num_pe_row      = 1,
  parameter int num_pe_col      = 4,
  parameter int total_num_pe    = num_pe_row * num_pe_col,
  parameter int output_width    = 24,
  parameter int max_entries     = DEF_MAX_ENTRIES,
  parameter int entry_cnt_width = entry_cnt_w(max_entries),
  parameter int col_width       = col_cnt_w(num_pe_col)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [entry_cnt_width-1:0]           num_entries,
  input  logic [total_num_pe-1:0]              pe_ctrl_ACCFIFO_empty,
  input  logic [num_pe_row*output_width-1:0]   out_fr_rightest_PE,
  output logic [total_num_pe-1:0]              pe_ctrl_ACCFIFO_read_to_outbuffer,
  output logic [total_num_pe-1:0]              pe_ctrl_out_mux_sel_PE,
  output logic [total_num_pe-1:0]              pe_ctrl_out_to_right_pe_en,
  output logic [total_num_pe-1:0]              pe_ctrl_ACCFIFO_write,
  output logic [total_num_pe-1:0]              pe_ctrl_feed_zero_to_accfifo,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [num_pe_row*output_width-1:0]   out_data,
  output logic [col_width-1:0]                 out_col,
  output logic [entry_cnt_width-1:0]           out_entry,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 underflow
);

  localparam logic [col_width-1:0]       LAST_COL = col_width'(num_pe_col - 1);
  localparam logic [entry_cnt_width-1:0] MAX_N    = entry_cnt_width'(max_entries);

  drain_state_t               state_reg, state_next;
  logic [col_width-1:0]       col_cnt_reg, col_cnt_next;
  logic [entry_cnt_width-1:0] entry_cnt_reg, entry_cnt_next;
  logic [entry_cnt_width-1:0] n_reg, n_next;
  logic                       underflow_reg, underflow_next;
  logic                       zero_done_reg, zero_done_next;

  logic last_col;
  logic load_c, read_c, sel_c, en_c;

  assign last_col = (col_cnt_reg == LAST_COL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_cnt_reg   <= '0;
      entry_cnt_reg <= '0;
      n_reg         <= '0;
      underflow_reg <= 1'b0;
      zero_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_cnt_reg   <= col_cnt_next;
      entry_cnt_reg <= entry_cnt_next;
      n_reg         <= n_next;
      underflow_reg <= underflow_next;
      zero_done_reg <= zero_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_cnt_next   = col_cnt_reg;
    entry_cnt_next = entry_cnt_reg;
    n_next         = n_reg;
    underflow_next = underflow_reg;
    zero_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (num_entries == '0) begin
            zero_done_next = 1'b1;
          end else begin
            n_next         = (num_entries > MAX_N) ? MAX_N : num_entries;
            entry_cnt_next = '0;
            col_cnt_next   = '0;
            underflow_next = 1'b0;
            state_next     = LOAD;
          end
        end
      end
      LOAD: begin
        // An empty FIFO is flagged but the drain still runs to keep rows aligned.
        if (|pe_ctrl_ACCFIFO_empty) underflow_next = 1'b1;
        col_cnt_next = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        if (out_ready) begin
          if (!last_col) begin
            col_cnt_next = col_cnt_reg + col_width'(1);
          end else if (entry_cnt_reg != n_reg - entry_cnt_width'(1)) begin
            entry_cnt_next = entry_cnt_reg + entry_cnt_width'(1);
            state_next     = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_c    = 1'b0;
    read_c    = 1'b0;
    sel_c     = 1'b0;
    en_c      = 1'b0;
    out_valid = 1'b0;
    out_col   = '0;
    out_entry = '0;
    case (state_reg)
      LOAD: begin
        load_c = 1'b1;
        read_c = 1'b1;
        sel_c  = 1'b1;
        en_c   = 1'b1;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_col   = LAST_COL - col_cnt_reg;
        out_entry = entry_cnt_reg;
        // A stall freezes the chain so out_data holds its word.
        en_c      = out_ready && !last_col;
      end
      default: ;
    endcase
  end

  assign pe_ctrl_ACCFIFO_read_to_outbuffer = total_num_pe'(broadcast(read_c));
  assign pe_ctrl_out_mux_sel_PE            = total_num_pe'(broadcast(sel_c));
  assign pe_ctrl_out_to_right_pe_en        = total_num_pe'(broadcast(en_c));

`ifdef PE_DRAIN_ZERO_REFILL_EN
  assign pe_ctrl_ACCFIFO_write        = total_num_pe'(broadcast(load_c));
  assign pe_ctrl_feed_zero_to_accfifo = total_num_pe'(broadcast(load_c));
`else
  assign pe_ctrl_ACCFIFO_write        = '0;
  assign pe_ctrl_feed_zero_to_accfifo = '0;
`endif

  assign out_data  = out_fr_rightest_PE;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE) || zero_done_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_pe_array_drain_ctrl.sv
// Self-checking bench: behavioural PE-array chain model plus a per-job beat schedule
// derived from the drain rules; covers table vectors, random jobs and C=1 corners.
module tb_pe_array_drain_ctrl;

  localparam int R    = 2;
  localparam int C    = 4;
  localparam int W    = 24;
  localparam int MAXE = 64;
  localparam int EW   = 7;
  localparam int CW   = 2;
  localparam int TOT  = R * C;
  localparam logic [TOT-1:0] ALL1 = '1;
`ifdef PE_DRAIN_ZERO_REFILL_EN
  localparam bit REFILL = 1'b1;
`else
  localparam bit REFILL = 1'b0;
`endif

  localparam int K_LOAD = 0;
  localparam int K_BEAT = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int e;
    int c;
  } ev_t;

  typedef struct {
    int n_in;
    int mode;
    int inj_e;
    int inj_pe;
    bit exp_uf;
    int exp_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [EW-1:0]    num_entries;
  logic [TOT-1:0]   empty;
  logic [R*W-1:0]   rightest;
  logic [TOT-1:0]   pe_read, pe_sel, pe_en, pe_wr, pe_fz;
  logic             out_valid, out_ready;
  logic [R*W-1:0]   out_data;
  logic [CW-1:0]    out_col;
  logic [EW-1:0]    out_entry;
  logic             busy, done, underflow;

  logic             c1_start;
  logic [EW-1:0]    c1_num;
  logic [0:0]       c1_empty;
  logic [W-1:0]     c1_rightest;
  logic [0:0]       c1_read, c1_sel, c1_en, c1_wr, c1_fz;
  logic             c1_valid, c1_done, c1_busy, c1_uf;
  logic [W-1:0]     c1_data;
  logic [0:0]       c1_col;
  logic [EW-1:0]    c1_entry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_array_drain_ctrl #(
    .num_pe_row(R), .num_pe_col(C), .output_width(W), .max_entries(MAXE)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_entries(num_entries),
    .pe_ctrl_ACCFIFO_empty(empty), .out_fr_rightest_PE(rightest),
    .pe_ctrl_ACCFIFO_read_to_outbuffer(pe_read), .pe_ctrl_out_mux_sel_PE(pe_sel),
    .pe_ctrl_out_to_right_pe_en(pe_en), .pe_ctrl_ACCFIFO_write(pe_wr),
    .pe_ctrl_feed_zero_to_accfifo(pe_fz), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_col(out_col), .out_entry(out_entry),
    .busy(busy), .done(done), .underflow(underflow)
  );

  pe_array_drain_ctrl #(
    .num_pe_row(1), .num_pe_col(1), .output_width(W), .max_entries(MAXE)
  ) u_dut_c1 (
    .clk(clk), .rst(rst), .start(c1_start), .num_entries(c1_num),
    .pe_ctrl_ACCFIFO_empty(c1_empty), .out_fr_rightest_PE(c1_rightest),
    .pe_ctrl_ACCFIFO_read_to_outbuffer(c1_read), .pe_ctrl_out_mux_sel_PE(c1_sel),
    .pe_ctrl_out_to_right_pe_en(c1_en), .pe_ctrl_ACCFIFO_write(c1_wr),
    .pe_ctrl_feed_zero_to_accfifo(c1_fz), .out_valid(c1_valid), .out_ready(1'b1),
    .out_data(c1_data), .out_col(c1_col), .out_entry(c1_entry),
    .busy(c1_busy), .done(c1_done), .underflow(c1_uf)
  );

  // PE array model: entry e of PE(r,c) holds 1000*r + 100*c + e.
  function automatic logic [W-1:0] head_val(input int r, input int c, input int e);
    return W'(1000 * r + 100 * c + e);
  endfunction

  int         rd_cnt [TOT];
  logic [W-1:0] chain [TOT];
  logic       env_clr = 1'b0;

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < TOT; i++) begin
        rd_cnt[i] <= 0;
        chain[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < TOT; i++) begin
        if (pe_en[i])
          chain[i] <= pe_sel[i] ? head_val(i / C, i % C, rd_cnt[i])
                                : ((i % C == 0) ? '0 : chain[(i == 0) ? 0 : i - 1]);
        if (pe_read[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_row
    assign rightest[gi*W +: W] = chain[gi*C + C - 1];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    ev_t sched[$];
    ev_t hd;
    int beat_idx, stall, cyc;
    logic [R*W-1:0] exp_d;
    logic [TOT-1:0] exp_en;
    for (int e = 0; e < v.exp_n; e++) begin
      sched.push_back('{kind: K_LOAD, e: e, c: 0});
      for (int j = 0; j < C; j++) sched.push_back('{kind: K_BEAT, e: e, c: C - 1 - j});
    end
    sched.push_back('{kind: K_DONE, e: 0, c: 0});

    @(negedge clk); env_clr = 1'b1;
    @(negedge clk); env_clr = 1'b0;
    start = 1'b1; num_entries = EW'(v.n_in); out_ready = 1'b1; empty = '0;
    beat_idx = 0; stall = 0; cyc = 0;
    while (sched.size() > 0) begin
      @(negedge clk);
      cyc++;
      hd = sched[0];
      // Starts arriving while busy must be ignored.
      start = (v.mode == 2) && ($urandom_range(0, 3) == 0);
      num_entries = EW'($urandom_range(0, 10));
      empty = (hd.kind == K_LOAD && hd.e == v.inj_e) ? (TOT'(1) << v.inj_pe) : '0;
      out_ready = 1'b1;
      if (hd.kind == K_BEAT) begin
        if (v.mode == 1 && beat_idx % 2 == 1 && stall < 3) out_ready = 1'b0;
        if (v.mode == 2 && stall < 4 && $urandom_range(0, 2) == 0) out_ready = 1'b0;
      end
      #1;
      if (hd.kind == K_LOAD) begin
        chk("load_valid", 64'(out_valid), 64'(0));
        chk("load_read", 64'(pe_read), 64'(ALL1));
        chk("load_sel", 64'(pe_sel), 64'(ALL1));
        chk("load_en", 64'(pe_en), 64'(ALL1));
        chk("load_write", 64'(pe_wr), REFILL ? 64'(ALL1) : 64'(0));
        chk("load_feed_zero", 64'(pe_fz), REFILL ? 64'(ALL1) : 64'(0));
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_done", 64'(done), 64'(0));
        void'(sched.pop_front());
      end else if (hd.kind == K_BEAT) begin
        for (int r = 0; r < R; r++) exp_d[r*W +: W] = head_val(r, hd.c, hd.e);
        exp_en = (out_ready && hd.c != 0) ? ALL1 : '0;
        chk("beat_valid", 64'(out_valid), 64'(1));
        chk("beat_col", 64'(out_col), 64'(hd.c));
        chk("beat_entry", 64'(out_entry), 64'(hd.e));
        chk("beat_data", 64'(out_data), 64'(exp_d));
        chk("beat_en", 64'(pe_en), 64'(exp_en));
        chk("beat_sel", 64'(pe_sel), 64'(0));
        chk("beat_read", 64'(pe_read), 64'(0));
        chk("beat_write", 64'(pe_wr), 64'(0));
        chk("beat_done", 64'(done), 64'(0));
        if (out_ready) begin
          void'(sched.pop_front());
          beat_idx++;
          stall = 0;
        end else begin
          stall++;
        end
      end else begin
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(1));
        chk("done_valid", 64'(out_valid), 64'(0));
        chk("done_en", 64'(pe_en), 64'(0));
        chk("done_underflow", 64'(underflow), 64'(v.exp_uf));
        void'(sched.pop_front());
      end
    end
    @(negedge clk);
    start = 1'b0; empty = '0; out_ready = 1'b1;
    #1;
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_done", 64'(done), 64'(0));
    chk("post_underflow", 64'(underflow), 64'(v.exp_uf));
    $display("job n_in=%0d entries=%0d mode=%0d beats=%0d cycles=%0d underflow=%0b",
             v.n_in, v.exp_n, v.mode, beat_idx, cyc, underflow);
  endtask

  vec_t tbl [6];
  vec_t rv;
  int   exp_v  [5];
  int   exp_rd [5];
  int   exp_dn [5];
  int   exp_en_c1 [5];

  initial begin
    tbl[0] = '{n_in: 3,  mode: 0, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: 3};
    tbl[1] = '{n_in: 3,  mode: 1, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: 3};
    tbl[2] = '{n_in: 3,  mode: 0, inj_e: 1,  inj_pe: 1*C+2, exp_uf: 1'b1, exp_n: 3};
    tbl[3] = '{n_in: 3,  mode: 0, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: 3};
    tbl[4] = '{n_in: 70, mode: 0, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: MAXE};
    tbl[5] = '{n_in: 1,  mode: 0, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: 1};

    rst = 1'b1; start = 1'b0; num_entries = '0; empty = '0; out_ready = 1'b1;
    c1_start = 1'b0; c1_num = '0; c1_empty = '0; c1_rightest = 24'hABCDEF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ctrls", 64'({pe_read, pe_sel, pe_en, pe_wr, pe_fz}), 64'(0));
    chk("rst_col_entry", 64'({out_col, out_entry}), 64'(0));
    chk("rst_underflow", 64'(underflow), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    // Zero-length job: done next cycle, never busy.
    @(negedge clk); start = 1'b1; num_entries = '0;
    @(negedge clk); start = 1'b0; #1;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk("zero_ctrls", 64'({pe_read, pe_sel, pe_en, out_valid}), 64'(0));
    @(negedge clk); #1;
    chk("zero_done_drop", 64'(done), 64'(0));
    chk("zero_busy2", 64'(busy), 64'(0));
    $display("job n_in=0 zero-length done=pulse");

    // Reset during SHIFT at col_cnt=2, with underflow set beforehand.
    @(negedge clk); start = 1'b1; num_entries = EW'(3);
    @(negedge clk); start = 1'b0; empty = ALL1;
    @(negedge clk); empty = '0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_col", 64'(out_col), 64'(C - 3));
    chk("pre_rst_underflow", 64'(underflow), 64'(1));
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_ctrls", 64'({pe_read, pe_sel, pe_en, pe_wr, pe_fz}), 64'(0));
    chk("midrst_underflow", 64'(underflow), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    rst = 1'b0;
    $display("job mid-shift reset");
    rv = '{n_in: 1, mode: 0, inj_e: -1, inj_pe: 0, exp_uf: 1'b0, exp_n: 1};
    run_job(rv);

    for (int k = 0; k < 8; k++) begin
      rv.n_in = int'($urandom_range(1, 6));
      rv.exp_n = rv.n_in;
      rv.mode = 2;
      rv.inj_e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rv.n_in - 1)) : -1;
      rv.inj_pe = int'($urandom_range(0, TOT - 1));
      rv.exp_uf = (rv.inj_e >= 0);
      run_job(rv);
    end

    // Single-column array, N=2: LOAD,SHIFT,LOAD,SHIFT,DONE.
    exp_v  = '{0, 1, 0, 1, 0};
    exp_rd = '{1, 0, 1, 0, 0};
    exp_dn = '{0, 0, 0, 0, 1};
    exp_en_c1 = '{1, 0, 1, 0, 0};
    @(negedge clk); c1_start = 1'b1; c1_num = EW'(2);
    @(negedge clk); c1_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("c1_valid", 64'(c1_valid), 64'(exp_v[k]));
      chk("c1_read", 64'(c1_read), 64'(exp_rd[k]));
      chk("c1_en", 64'(c1_en), 64'(exp_en_c1[k]));
      chk("c1_write", 64'(c1_wr), 64'(REFILL ? exp_rd[k] : 0));
      chk("c1_feed_zero", 64'(c1_fz), 64'(REFILL ? exp_rd[k] : 0));
      chk("c1_done", 64'(c1_done), 64'(exp_dn[k]));
      if (exp_v[k] == 1) begin
        chk("c1_col", 64'(c1_col), 64'(0));
        chk("c1_entry", 64'(c1_entry), 64'(k / 2));
        chk("c1_data", 64'(c1_data), 64'(24'hABCDEF));
      end
      @(negedge clk);
    end
    #1;
    chk("c1_idle", 64'({c1_busy, c1_done, c1_uf}), 64'(0));
    $display("job c1 n_in=2 beats=2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_drain_ctrl.md
Name: pe_array_drain_ctrl

Overview:
- Sequences the drain of accumulated results out of the PE array's output-buffer ACCFIFOs.
- Each result is shifted rightward along the systolic chain and collected at the rightmost PE of every row.
- Sits between the array top level and the output buffer, and drives the per-PE drain controls; all rows are controlled in lockstep.
- Presents one word per row per beat to the output buffer over a valid/ready handshake.

Parameters:
num_pe_row, 1, PE rows (R)
num_pe_col, 4, PE columns (C), >=1
total_num_pe, num_pe_row*num_pe_col, derived
output_width, 24, systolic chain word width
max_entries, 64, max ACCFIFO entries drained per job
entry_cnt_width, $clog2(max_entries+1), width of the entry count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job start pulse; ignored while busy
num_entries  in  entry_cnt_width  entries per PE to drain, sampled on start
pe_ctrl_ACCFIFO_empty  in  total_num_pe  per-PE ACCFIFO empty
out_fr_rightest_PE  in  R*output_width  chain outputs, one per row
pe_ctrl_ACCFIFO_read_to_outbuffer  out  total_num_pe  head read toward the output buffer
pe_ctrl_out_mux_sel_PE  out  total_num_pe  1 = own ACCFIFO head, 0 = left PE
pe_ctrl_out_to_right_pe_en  out  total_num_pe  chain register enable
pe_ctrl_ACCFIFO_write  out  total_num_pe  used only with the optional feature
pe_ctrl_feed_zero_to_accfifo  out  total_num_pe  used only with the optional feature
out_valid  out  1  out_data valid
out_ready  in  1  output buffer accepts
out_data  out  R*output_width  equals out_fr_rightest_PE
out_col  out  $clog2(C)  source column of out_data (0 when C=1)
out_entry  out  entry_cnt_width  entry index of out_data
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
underflow  out  1  sticky: an ACCFIFO was empty at a LOAD

Behaviour:
- Reset: state IDLE, counters 0. Every output except out_data is 0; out_data is pure combinational passthrough. A reset mid-job aborts immediately and clears underflow.
- Per-PE control outputs are the same value broadcast to all total_num_pe bits.
- IDLE:
  - All controls 0, busy=0.
  - start with num_entries=0: done=1 next cycle, remain IDLE.
  - start with num_entries>0: latch N=num_entries (saturate at max_entries), clear underflow, go to LOAD.
- LOAD (1 cycle):
  - Drive read_to_outbuffer=1, out_mux_sel_PE=1, out_to_right_pe_en=1.
  - If any ACCFIFO_empty bit is set, set underflow=1 and proceed anyway.
  - Next state SHIFT with col_cnt=0.
- SHIFT:
  - out_valid=1; out_col = C-1-col_cnt; out_entry = entry_cnt.
  - On out_valid&&out_ready:
    - col_cnt<C-1: out_to_right_pe_en=1, out_mux_sel_PE=0, col_cnt++.
    - col_cnt==C-1 and entry_cnt<N-1: entry_cnt++, go to LOAD.
    - col_cnt==C-1 and entry_cnt==N-1: go to DONE.
  - On !out_ready: every enable 0, chain frozen, out_valid held with out_data stable.
- DONE: done=1 for one cycle, busy falls to 0, go to IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Latency:
  - start to first out_valid: 2 cycles.
  - Throughput: C beats per C+1 cycles with ready held high.
  - Job length with ready high: N*(C+1)+1 cycles from start to done.
- C=1: every SHIFT beat is the last column.
- start while busy: ignored, with no effect.
- Word order per row per entry: column C-1 first, then down to column 0.

Optional Feature:
- Macro: PE_DRAIN_ZERO_REFILL_EN.
  - Defined: in every LOAD cycle also drive ACCFIFO_write=1 and feed_zero_to_accfifo=1. Each drained entry is replaced by zero, so accumulators are re-initialised for the next layer with no extra pass.
  - Undefined: both outputs are tied to 0 and the ACCFIFO occupancy drops by N.

Decomposition:
- Shared package pe_array_ctrl_pkg holds:
  - enum drain_state_t {IDLE, LOAD, SHIFT, DONE}
  - the entry/column width localparams
  - a broadcast helper function that replicates a 1-bit control to total_num_pe bits
- No sub-module is needed. The FSM and the two counters live in one module.

Test Plan:
- C=4, R=2, N=3, ready held high, each PE holds entries 100*col+entry. Expect 12 beats per row in order (col3,e0),(col2,e0)…(col0,e2). done arrives 16 cycles after start; underflow=0.
- Same setup, but out_ready low on every odd beat for 3 cycles. Expect no lost or duplicated word, out_data stable while stalled, and all enables 0 during stalls.
- start with num_entries=0. Expect done pulse on the next cycle, busy never high, all controls 0.
- At the second LOAD, PE(1,2) reports ACCFIFO empty. Expect underflow=1 held until the next start; the job still completes 12 beats.
- Assert rst during SHIFT at col_cnt=2. Next cycle: IDLE, all outputs 0. A new start with N=1 then completes normally.
- C=1, N=2 with the macro defined. Expect 2 beats, and ACCFIFO_write plus feed_zero both asserted in both LOAD cycles only.
